// File: rtl/axi4_lite_cmd_master.sv
// AXI4-Lite master that converts single-beat write/read command pulses into one
// outstanding AXI4-Lite transaction at a time, with a saturating timeout watchdog.
module axi4_lite_cmd_master #(
    parameter int AXI_DATA_WIDTH_P = 32,
    parameter int AXI_ADDR_WIDTH_P = 32,
    parameter int TIMEOUT_CYCLES_P = 1024
) (
    input  logic                          clk,
    input  logic                          rst_n,
    // command side
    input  logic                          cmd_write,
    input  logic                          cmd_read,
    input  logic [AXI_ADDR_WIDTH_P-1:0]   cmd_addr,
    input  logic [AXI_DATA_WIDTH_P-1:0]   cmd_wdata,
    input  logic [AXI_DATA_WIDTH_P/8-1:0] cmd_wstrb,
    output logic                          cmd_busy,
    output logic                          cmd_dropped,
    output logic                          rsp_valid,
    output logic [AXI_DATA_WIDTH_P-1:0]   rsp_rdata,
    output logic [1:0]                    rsp_resp,
    output logic                          rsp_timeout,
    // AW channel
    output logic [AXI_ADDR_WIDTH_P-1:0]   awaddr,
    output logic                          awvalid,
    input  logic                          awready,
    // W channel
    output logic [AXI_DATA_WIDTH_P-1:0]   wdata,
    output logic [AXI_DATA_WIDTH_P/8-1:0] wstrb,
    output logic                          wvalid,
    input  logic                          wready,
    // B channel
    input  logic [1:0]                    bresp,
    input  logic                          bvalid,
    output logic                          bready,
    // AR channel
    output logic [AXI_ADDR_WIDTH_P-1:0]   araddr,
    output logic                          arvalid,
    input  logic                          arready,
    // R channel
    input  logic [AXI_DATA_WIDTH_P-1:0]   rdata,
    input  logic [1:0]                    rresp,
    input  logic                          rvalid,
    output logic                          rready,
    // FSM state for debug/checkers: 0 IDLE, 1 WRITE, 2 WRITE_RESP, 3 READ_ADDR, 4 READ_DATA
    output logic [2:0]                    dbg_state
);

    // Handshakes: a transfer happens on any rising clk edge where valid && ready.
    // This master never waits for a ready before raising its own valid, and once
    // a valid is raised it and its payload stay put until that transfer happens
    // (or the watchdog aborts the whole transaction).

    localparam int CNT_W     = $clog2(TIMEOUT_CYCLES_P + 1) + 1;
    localparam int WDOG_LAST = (TIMEOUT_CYCLES_P > 0) ? TIMEOUT_CYCLES_P - 1 : 0;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WRITE      = 3'd1,
        WRITE_RESP = 3'd2,
        READ_ADDR  = 3'd3,
        READ_DATA  = 3'd4
    } state_t;

    state_t                        state_q, state_d;
    logic [CNT_W-1:0]              wdog_cnt;
    logic                          done_q;
    logic [AXI_DATA_WIDTH_P-1:0]   cap_rdata;
    logic [1:0]                    cap_resp;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic accept_wr, accept_rd, drop, wr_both_done, timeout_hit, finish;

    assign cmd_busy  = (state_q != IDLE);
    assign dbg_state = state_q;

    always_comb begin
        aw_hs        = awvalid & awready;
        w_hs         = wvalid & wready;
        b_hs         = bvalid & bready;
        ar_hs        = arvalid & arready;
        r_hs         = rvalid & rready;
        accept_wr    = (state_q == IDLE) & cmd_write;
        accept_rd    = (state_q == IDLE) & cmd_read & ~cmd_write;
        drop         = (state_q == IDLE) ? (cmd_write & cmd_read) : (cmd_write | cmd_read);
        wr_both_done = (~awvalid | aw_hs) & (~wvalid | w_hs);
        // A completed handshake (done_q) always takes priority over the watchdog.
        timeout_hit  = (TIMEOUT_CYCLES_P != 0) && (state_q != IDLE) && !done_q &&
                       (wdog_cnt >= CNT_W'(WDOG_LAST));
    end

    always_comb begin
        state_d = state_q;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_wr)      state_d = WRITE;
                else if (accept_rd) state_d = READ_ADDR;
            end
            WRITE: begin
                if (timeout_hit)       state_d = IDLE;
                else if (wr_both_done) state_d = WRITE_RESP;
            end
            WRITE_RESP: begin
                if (done_q) begin
                    state_d = IDLE;
                    finish  = 1'b1;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                end
            end
            READ_ADDR: begin
                if (timeout_hit) state_d = IDLE;
                else if (ar_hs)  state_d = READ_DATA;
            end
            READ_DATA: begin
                if (done_q) begin
                    state_d = IDLE;
                    finish  = 1'b1;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            awaddr      <= '0;
            awvalid     <= 1'b0;
            wdata       <= '0;
            wstrb       <= '0;
            wvalid      <= 1'b0;
            bready      <= 1'b0;
            araddr      <= '0;
            arvalid     <= 1'b0;
            rready      <= 1'b0;
            cmd_dropped <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_resp    <= 2'b00;
            rsp_timeout <= 1'b0;
            done_q      <= 1'b0;
            cap_rdata   <= '0;
            cap_resp    <= 2'b00;
            wdog_cnt    <= '0;
        end else begin
            rsp_valid   <= 1'b0;
            cmd_dropped <= drop;

            if (accept_wr) begin
                awaddr  <= cmd_addr;
                wdata   <= cmd_wdata;
                wstrb   <= cmd_wstrb;
                awvalid <= 1'b1;
                wvalid  <= 1'b1;
            end
            if (accept_rd) begin
                araddr  <= cmd_addr;
                arvalid <= 1'b1;
            end

            if (aw_hs) awvalid <= 1'b0;
            if (w_hs)  wvalid  <= 1'b0;
            if ((state_q == WRITE) && wr_both_done) bready <= 1'b1;
            if (b_hs) begin
                bready    <= 1'b0;
                done_q    <= 1'b1;
                cap_resp  <= bresp;
                cap_rdata <= '0;
            end

            if (ar_hs) begin
                arvalid <= 1'b0;
                rready  <= 1'b1;
            end
            if (r_hs) begin
                rready    <= 1'b0;
                done_q    <= 1'b1;
                cap_resp  <= rresp;
                cap_rdata <= rdata;
            end

            // Response fields only change together with a rsp_valid pulse.
            if (finish) begin
                done_q      <= 1'b0;
                rsp_valid   <= 1'b1;
                rsp_rdata   <= cap_rdata;
                rsp_resp    <= cap_resp;
                rsp_timeout <= 1'b0;
            end

            if (timeout_hit) begin
                awvalid     <= 1'b0;
                wvalid      <= 1'b0;
                bready      <= 1'b0;
                arvalid     <= 1'b0;
                rready      <= 1'b0;
                done_q      <= 1'b0;
                rsp_valid   <= 1'b1;
                rsp_rdata   <= '0;
                rsp_resp    <= 2'b10;
                rsp_timeout <= 1'b1;
            end

            if (accept_wr || accept_rd)
                wdog_cnt <= '0;
            else if ((state_q != IDLE) && (wdog_cnt != {CNT_W{1'b1}}))
                wdog_cnt <= wdog_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_axi4_lite_cmd_master.sv
// Directed bench for axi4_lite_cmd_master: a configurable-latency AXI4-Lite slave,
// a negedge monitor, and hand-computed expectations per transaction.
module tb_axi4_lite_cmd_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_write = 1'b0, cmd_read = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        cmd_busy, cmd_dropped, rsp_valid, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] awaddr, wdata, araddr;
    logic [3:0]  wstrb;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
    logic [1:0]  bresp = 2'b00, rresp = 2'b00;
    logic [31:0] rdata = '0;
    logic [2:0]  dbg_state;

    axi4_lite_cmd_master #(
        .AXI_DATA_WIDTH_P(32),
        .AXI_ADDR_WIDTH_P(32),
        .TIMEOUT_CYCLES_P(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_write(cmd_write), .cmd_read(cmd_read), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .cmd_busy(cmd_busy), .cmd_dropped(cmd_dropped),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- slave configuration ----------------
    int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic        ar_never = 1'b0;
    logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
    logic [31:0] cfg_rdata = '0;
    int          aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;

    // Slave updates just after each rising edge so every value is stable for a whole cycle.
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
            aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
        end else begin
            if (awready) awready = 0;
            else if (awvalid) begin
                if (aw_wait >= aw_dly) begin awready = 1; aw_wait = 0; end else aw_wait++;
            end
            if (wready) wready = 0;
            else if (wvalid) begin
                if (w_wait >= w_dly) begin wready = 1; w_wait = 0; end else w_wait++;
            end
            if (bvalid) bvalid = 0;
            else if (bready) begin
                if (b_wait >= b_dly) begin bvalid = 1; bresp = cfg_bresp; b_wait = 0; end else b_wait++;
            end
            if (arready) arready = 0;
            else if (arvalid && !ar_never) begin
                if (ar_wait >= ar_dly) begin arready = 1; ar_wait = 0; end else ar_wait++;
            end
            if (rvalid) rvalid = 0;
            else if (rready) begin
                if (r_wait >= r_dly) begin
                    rvalid = 1; rdata = cfg_rdata; rresp = cfg_rresp; r_wait = 0;
                end else r_wait++;
            end
        end
    end

    // ---------------- monitor ----------------
    logic        mon_clr = 1'b0;
    logic [31:0] exp_awaddr = '0, exp_wdata = '0;
    logic [3:0]  exp_wstrb = '0;
    int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt, rsp_cnt, drop_cnt, proto_bad;
    int awv_cyc, wv_cyc, arv_cyc, rr_cyc, busy_cyc, rsp_cyc;
    logic [31:0] got_awaddr, got_wdata, got_araddr, got_rdata;
    logic [3:0]  got_wstrb;
    logic [1:0]  got_resp;
    logic        got_timeout, busy_at_rsp;

    always @(negedge clk) begin
        if (mon_clr) begin
            aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0; rsp_cnt = 0; drop_cnt = 0;
            proto_bad = 0; awv_cyc = 0; wv_cyc = 0; arv_cyc = 0; rr_cyc = 0; busy_cyc = 0;
            rsp_cyc = 0; got_awaddr = 0; got_wdata = 0; got_araddr = 0; got_rdata = 0;
            got_wstrb = 0; got_resp = 0; got_timeout = 0; busy_at_rsp = 0;
        end else if (rst_n) begin
            if (awvalid && awready) begin aw_cnt++; got_awaddr = awaddr; end
            if (wvalid && wready) begin w_cnt++; got_wdata = wdata; got_wstrb = wstrb; end
            if (bvalid && bready) b_cnt++;
            if (arvalid && arready) begin ar_cnt++; got_araddr = araddr; end
            if (rvalid && rready) r_cnt++;
            if (awvalid) awv_cyc++;
            if (wvalid) wv_cyc++;
            if (arvalid) arv_cyc++;
            if (rready) rr_cyc++;
            if (cmd_busy) busy_cyc++;
            if (cmd_dropped) drop_cnt++;
            if (awvalid && awaddr != exp_awaddr) proto_bad++;
            if (wvalid && (wdata != exp_wdata || wstrb != exp_wstrb)) proto_bad++;
            if (bready && (awvalid || wvalid)) proto_bad++;
            if (rready && dbg_state != 3'd4) proto_bad++;
            if (rsp_valid) begin
                rsp_cnt++; rsp_cyc = cyc; got_rdata = rsp_rdata; got_resp = rsp_resp;
                got_timeout = rsp_timeout; busy_at_rsp = cmd_busy;
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    int checks = 0, errors = 0;
    int t0 = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic mon_clear();
        @(posedge clk);
        mon_clr = 1'b1;
        @(negedge clk);
        #1 mon_clr = 1'b0;
    endtask

    task automatic issue(input logic wr, input logic rd, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] strb);
        if (wr) begin exp_awaddr = addr; exp_wdata = data; exp_wstrb = strb; end
        @(negedge clk);
        cmd_write = wr; cmd_read = rd; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
        t0 = cyc;
        @(negedge clk);
        cmd_write = 1'b0; cmd_read = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input int max_cyc);
        int n = 0;
        while (rsp_cnt == 0 && n < max_cyc) begin
            @(negedge clk); #1;
            n++;
        end
        check_eq({tag, "_rsp_seen"}, (rsp_cnt != 0), 1);
        repeat (3) @(negedge clk);
        #1;
    endtask

    task automatic check_rsp(input string tag, input int lat, input logic [1:0] resp,
                             input logic tmo);
        check_eq({tag, "_rsp_count"}, rsp_cnt, 1);
        check_eq({tag, "_latency"}, rsp_cyc - t0, lat);
        check_eq({tag, "_rdata"}, got_rdata, exp_q.pop_front());
        check_eq({tag, "_resp"}, got_resp, resp);
        check_eq({tag, "_timeout"}, got_timeout, tmo);
        check_eq({tag, "_busy_at_rsp"}, busy_at_rsp, 0);
        check_eq({tag, "_proto"}, proto_bad, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int base_rsp;
        mon_clr = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("reset_ctrl", {awvalid, wvalid, bready, arvalid, rready, cmd_busy,
                                cmd_dropped, rsp_valid, rsp_timeout}, 0);
        check_eq("reset_awaddr", awaddr, 0);
        check_eq("reset_wdata_wstrb", {wdata, wstrb}, 0);
        check_eq("reset_araddr", araddr, 0);
        check_eq("reset_rsp", {rsp_rdata, rsp_resp}, 0);
        rst_n = 1'b1;
        #1 mon_clr = 1'b0;

        // Zero-wait write.
        mon_clear();
        exp_q.push_back(32'h0);
        issue(1, 0, 32'h0000_0004, 32'hCAFE_F00D, 4'hF);
        wait_rsp("t1", 40);
        check_rsp("t1", 4, 2'b00, 0);
        check_eq("t1_hs_counts", {8'(aw_cnt), 8'(w_cnt), 8'(b_cnt), 8'(ar_cnt)}, 32'h01010100);
        check_eq("t1_awaddr", got_awaddr, 32'h0000_0004);
        check_eq("t1_wdata", got_wdata, 32'hCAFE_F00D);
        check_eq("t1_wstrb", got_wstrb, 4'hF);
        check_eq("t1_busy_cycles", busy_cyc, 3);

        // W accepted 3 cycles before AW; SLVERR passes through.
        mon_clear();
        aw_dly = 3; cfg_bresp = 2'b10;
        exp_q.push_back(32'h0);
        issue(1, 0, 32'h0000_0010, 32'h1234_5678, 4'h3);
        wait_rsp("t3", 40);
        check_rsp("t3", 7, 2'b10, 0);
        check_eq("t3_hs_counts", {8'(aw_cnt), 8'(w_cnt), 8'(b_cnt)}, 24'h010101);
        check_eq("t3_wvalid_cycles", wv_cyc, 1);
        check_eq("t3_awvalid_cycles", awv_cyc, 4);
        check_eq("t3_awaddr", got_awaddr, 32'h0000_0010);
        aw_dly = 0; cfg_bresp = 2'b00;

        // Simultaneous write+read, then a read while busy.
        mon_clear();
        exp_awaddr = 32'h0000_0030; exp_wdata = 32'h0BAD_BEEF; exp_wstrb = 4'hC;
        exp_q.push_back(32'h0);
        @(negedge clk);
        cmd_write = 1; cmd_read = 1; cmd_addr = 32'h0000_0030; cmd_wdata = 32'h0BAD_BEEF;
        cmd_wstrb = 4'hC; t0 = cyc;
        @(negedge clk);
        cmd_write = 0; cmd_read = 0;
        @(negedge clk);
        cmd_read = 1;
        @(negedge clk);
        cmd_read = 0;
        wait_rsp("t4", 40);
        check_rsp("t4", 4, 2'b00, 0);
        check_eq("t4_dropped", drop_cnt, 2);
        check_eq("t4_ar_activity", {8'(ar_cnt), 8'(arv_cyc)}, 0);
        check_eq("t4_aw_w", {8'(aw_cnt), 8'(w_cnt)}, 16'h0101);
        check_eq("t4_wstrb", got_wstrb, 4'hC);

        // Read with 3 wait cycles on R.
        mon_clear();
        r_dly = 3; cfg_rdata = 32'h0000_0102;
        exp_q.push_back(32'h0000_0102);
        issue(0, 1, 32'h0000_001C, 32'h0, 4'h0);
        wait_rsp("t2", 40);
        check_rsp("t2", 7, 2'b00, 0);
        check_eq("t2_araddr", got_araddr, 32'h0000_001C);
        check_eq("t2_rready_cycles", rr_cyc, 4);
        check_eq("t2_hs_counts", {8'(aw_cnt), 8'(ar_cnt), 8'(r_cnt)}, 24'h000101);
        r_dly = 0;

        // Watchdog: AR never accepted.
        mon_clear();
        ar_never = 1'b1;
        exp_q.push_back(32'h0);
        issue(0, 1, 32'h0000_0020, 32'h0, 4'h0);
        wait_rsp("t5", 40);
        check_rsp("t5", 17, 2'b10, 1);
        check_eq("t5_arvalid_cycles", arv_cyc, 16);
        check_eq("t5_idle_after", {arvalid, rready, cmd_busy}, 0);
        ar_never = 1'b0;

        mon_clear();
        cfg_rdata = 32'hA5A5_0F0F;
        exp_q.push_back(32'hA5A5_0F0F);
        issue(0, 1, 32'h0000_0024, 32'h0, 4'h0);
        wait_rsp("t5b", 40);
        check_rsp("t5b", 4, 2'b00, 0);
        check_eq("t5b_araddr", got_araddr, 32'h0000_0024);

        // Reset in READ_DATA.
        mon_clear();
        r_dly = 5; cfg_rdata = 32'hDEAD_0000;
        issue(0, 1, 32'h0000_0028, 32'h0, 4'h0);
        n = 0;
        while (!rready && n < 20) begin @(negedge clk); #1; n++; end
        check_eq("t6_reached_read_data", rready, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("t6_rready_dropped", rready, 0);
        check_eq("t6_busy_dropped", cmd_busy, 0);
        base_rsp = rsp_cnt;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        check_eq("t6_no_rsp", rsp_cnt - base_rsp, 0);
        check_eq("t6_rsp_valid_low", rsp_valid, 0);
        r_dly = 0;

        mon_clear();
        cfg_rdata = 32'h1357_9BDF;
        exp_q.push_back(32'h1357_9BDF);
        issue(0, 1, 32'h0000_002C, 32'h0, 4'h0);
        wait_rsp("t6b", 40);
        check_rsp("t6b", 4, 2'b00, 0);
        check_eq("t6b_araddr", got_araddr, 32'h0000_002C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi4_lite_cmd_master.md
Name: axi4_lite_cmd_master

Overview:
AXI4-Lite master that turns single-beat write/read commands into AXI4-Lite transactions and returns the response. It is the initiator counterpart to the team's register AXI slaves. It is driven from control-register command pulses (address, wdata, write/read strobes) so the PS or a test sequencer can poke any AXI4-Lite slave in the fabric. It issues one outstanding transaction at a time and has a timeout watchdog.

Parameters:
AXI_DATA_WIDTH_P, 32, data width in bits (32 or 64)
AXI_ADDR_WIDTH_P, 32, address width in bits
TIMEOUT_CYCLES_P, 1024, cycles allowed in any non-idle state before abort; 0 disables the watchdog

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cmd_write  in  1  single-cycle write command pulse
cmd_read  in  1  single-cycle read command pulse
cmd_addr  in  AXI_ADDR_WIDTH_P  command address
cmd_wdata  in  AXI_DATA_WIDTH_P  write data
cmd_wstrb  in  AXI_DATA_WIDTH_P/8  write byte strobes
cmd_busy  out  1  transaction in progress
cmd_dropped  out  1  one-cycle pulse: command ignored
rsp_valid  out  1  one-cycle pulse: transaction finished
rsp_rdata  out  AXI_DATA_WIDTH_P  read data (0 for writes or timeout)
rsp_resp  out  2  BRESP/RRESP; 2'b10 on timeout
rsp_timeout  out  1  qualifies rsp_valid: watchdog abort
awaddr, awvalid, awready(in)  AW channel
wdata, wstrb, wvalid, wready(in)  W channel
bresp(in) 2, bvalid(in), bready  B channel
araddr, arvalid, arready(in)  AR channel
rdata(in), rresp(in) 2, rvalid(in), rready  R channel

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset: all outputs 0 (all valid/ready signals, cmd_busy, cmd_dropped, rsp_*, awaddr, wdata, wstrb, araddr). The FSM goes to IDLE and the timeout counter clears.
- Reset mid-transaction: outputs drop asynchronously. No response is generated.
- States: IDLE, WRITE, WRITE_RESP, READ_ADDR, READ_DATA.
- Command acceptance:
  - A command is accepted only in IDLE.
  - On accept, the command fields are latched into the AXI output registers and cmd_busy=1 on the next cycle.
- Arbitration and drops:
  - If cmd_write and cmd_read arrive in the same cycle, the write wins. The read is dropped and cmd_dropped pulses the next cycle.
  - Any command arriving while not in IDLE is dropped with a cmd_dropped pulse.
- WRITE:
  - awvalid and wvalid both assert 1 cycle after accept.
  - Each deasserts independently in the cycle after its own valid&ready handshake.
  - Addr/data/strb are held stable while the corresponding valid is high.
  - When both handshakes are done (same cycle or different cycles), go to WRITE_RESP with bready=1.
- WRITE_RESP: on bvalid&bready, capture bresp into rsp_resp, clear bready, pulse rsp_valid next cycle, return to IDLE.
- READ_ADDR: arvalid asserts 1 cycle after accept. On arready, clear arvalid, set rready=1, go to READ_DATA.
- READ_DATA: on rvalid&rready, capture rdata/rresp, clear rready, pulse rsp_valid next cycle, return to IDLE.
- Response timing:
  - rsp_rdata/rsp_resp/rsp_timeout are held until the next rsp_valid.
  - In the rsp_valid cycle cmd_busy=0, so a new command can be accepted in that same cycle.
- Minimum latency (zero-wait slave): accept to rsp_valid = 4 cycles for write, 4 for read.
- Watchdog:
  - The counter resets on accept and increments every cycle outside IDLE.
  - On reaching TIMEOUT_CYCLES_P, all valid/ready outputs drop next cycle and the FSM returns to IDLE.
  - rsp_valid pulses with rsp_timeout=1, rsp_resp=2'b10, rsp_rdata=0.
  - The counter saturates and never wraps.
- Never asserts a valid that depends on a ready (AXI rule). No outstanding transactions beyond one.

Test Plan:
1. cmd_write addr 0x0000_0004, wdata 0xCAFE_F00D, wstrb 0xF; slave ready immediately, bresp 0 -> AW/W carry those values for exactly one handshake, one B handshake, rsp_valid once, rsp_resp 0, cmd_busy high from accept+1 until the rsp_valid cycle.
2. cmd_read addr 0x0000_001C; slave returns rdata 0x0000_0102, rresp 0 after 3 wait cycles -> rsp_rdata 0x0000_0102, rsp_resp 0, rready high only in READ_DATA.
3. Write where wready comes 3 cycles before awready -> wvalid drops after its handshake, awvalid held with awaddr stable, bready only after AW completes, single rsp_valid.
4. cmd_write and cmd_read in the same cycle, then cmd_read while busy -> write executes, cmd_dropped pulses twice, no AR handshake ever.
5. TIMEOUT_CYCLES_P=16, arready tied 0 -> arvalid drops 16 cycles after accept, rsp_valid with rsp_timeout=1, rsp_resp 2'b10, rsp_rdata 0; a following read to a responsive slave completes normally.
6. rst_n asserted during READ_DATA -> rready/cmd_busy drop immediately, no rsp_valid; a read after release returns correct data.
